// File: rtl/div_param_seq_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and state helpers.
package div_param_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic is_busy_state(input state_e s);
    return (s == ST_CALC) || (s == ST_FIX);
  endfunction

endpackage

// File: rtl/div_param_seq_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_param_seq_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             dvd_msb_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic             qbit_o
);

  logic [WIDTH+1:0] shifted_s;
  logic [WIDTH:0]   diff_s;
  logic             ge_s;

  always_comb begin
    shifted_s = {rem_i, dvd_msb_i};
    ge_s      = shifted_s >= {2'b00, dvs_i};
    // When ge_s holds the difference is below the divisor, so WIDTH+1 bits suffice.
    diff_s    = shifted_s[WIDTH:0] - {1'b0, dvs_i};
    qbit_o    = ge_s;
    if (ge_s) begin
      rem_o = diff_s;
    end else begin
      rem_o = shifted_s[WIDTH:0];
    end
  end

endmodule

// File: rtl/div_param_seq.sv
// Parametrised sequential signed/unsigned divider: sign pre-processing, WIDTH restoring
// steps, sign fix-up, with early completion for divide-by-zero and signed MIN/-1.
module div_param_seq
  import div_param_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             overflow
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return (~v) + ONE;
  endfunction

  // Two's-complement MIN maps to itself, which read as unsigned is the correct magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? negate(v) : v;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] res_r_q, res_r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic             ov_q, ov_d;

  logic [WIDTH:0]   step_rem_s;
  logic             step_qbit_s;

  div_param_seq_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .dvd_msb_i (dvd_q[WIDTH-1]),
    .dvs_i     (dvs_q),
    .rem_o     (step_rem_s),
    .qbit_o    (step_qbit_s)
  );

  // Next-state and datapath computation for the divider FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    quo_d   = quo_q;
    res_r_d = res_r_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dz_d = 1'b0;
          ov_d = 1'b0;
          if (B == {WIDTH{1'b0}}) begin
            state_d = ST_DONE;
            quo_d   = ONES;
            res_r_d = A;
            dz_d    = 1'b1;
          end else if (signed_op && (A == MIN_VAL) && (B == ONES)) begin
            state_d = ST_DONE;
            quo_d   = MIN_VAL;
            res_r_d = {WIDTH{1'b0}};
            ov_d    = 1'b1;
          end else begin
            state_d = ST_CALC;
            dvd_d   = magnitude(A, signed_op);
            dvs_d   = magnitude(B, signed_op);
            rem_d   = {(WIDTH+1){1'b0}};
            cnt_d   = {CNT_W{1'b0}};
            qneg_d  = signed_op & (A[WIDTH-1] ^ B[WIDTH-1]);
            rneg_d  = signed_op & A[WIDTH-1];
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        // Quotient bits fill the dividend register from the LSB as its MSBs are consumed.
        rem_d = step_rem_s;
        dvd_d = {dvd_q[WIDTH-2:0], step_qbit_s};
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_FIX: begin
        quo_d   = qneg_q ? negate(dvd_q) : dvd_q;
        res_r_d = rneg_q ? negate(rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = is_busy_state(state_d);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers; reset clears everything and aborts any operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      dvd_q   <= {WIDTH{1'b0}};
      dvs_q   <= {WIDTH{1'b0}};
      rem_q   <= {(WIDTH+1){1'b0}};
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      quo_q   <= {WIDTH{1'b0}};
      res_r_q <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      quo_q   <= quo_d;
      res_r_q <= res_r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
    end
  end

  assign Q        = quo_q;
  assign R        = res_r_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign overflow = ov_q;

endmodule

// File: tb/tb_div_param_seq.sv
// Directed, table-driven bench for div_param_seq at WIDTH=8 and WIDTH=16.
module tb_div_param_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start8, sop8, start16, sop16;
  logic [7:0]  a8, b8, q8, r8;
  logic [15:0] a16, b16, q16, r16;
  logic        busy8, done8, dz8, ov8, busy16, done16, dz16, ov16;

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  div_param_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .signed_op(sop8), .A(a8), .B(b8),
    .Q(q8), .R(r8), .busy(busy8), .done(done8), .div_zero(dz8), .overflow(ov8)
  );

  div_param_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .signed_op(sop16), .A(a16), .B(b16),
    .Q(q16), .R(r16), .busy(busy16), .done(done16), .div_zero(dz16), .overflow(ov16)
  );

  typedef struct {
    logic       sop;
    logic [7:0] a, b, q, r;
    logic       dz, ov;
    int         lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one operation; lat is the cycle (1 = cycle right after the start edge) in which done is seen.
  task automatic run_op(input bit w16, input logic sop, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] q, output logic [15:0] r, output logic dz,
                        output logic ov, output int lat, output int busy_n, output logic narrow);
    @(negedge clk);
    if (w16) begin sop16 = sop; a16 = a; b16 = b; start16 = 1'b1; end
    else begin sop8 = sop; a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    start16 = 1'b0;
    lat = 0;
    busy_n = 0;
    for (int k = 1; k <= 200; k++) begin
      if (w16 ? busy16 : busy8) busy_n++;
      if (w16 ? done16 : done8) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    q  = w16 ? q16 : {8'h00, q8};
    r  = w16 ? r16 : {8'h00, r8};
    dz = w16 ? dz16 : dz8;
    ov = w16 ? ov16 : ov8;
    @(negedge clk);
    narrow = w16 ? ~done16 : ~done8;
  endtask

  logic [15:0] q, r;
  logic        dz, ov, narrow;
  int          lat, busy_n, d1, d2;

  initial begin
    reset = 1'b1; start8 = 1'b0; start16 = 1'b0; sop8 = 1'b0; sop16 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; a16 = 16'h0000; b16 = 16'h0000;

    vecs[0]  = '{1'b0, 8'd255, 8'd10,  8'd25,  8'd5,   1'b0, 1'b0, 10};
    vecs[1]  = '{1'b0, 8'd100, 8'd0,   8'd255, 8'd100, 1'b1, 1'b0, 1};
    vecs[2]  = '{1'b0, 8'd17,  8'd5,   8'd3,   8'd2,   1'b0, 1'b0, 10};
    vecs[3]  = '{1'b1, 8'hEF,  8'd5,   8'hFD,  8'hFE,  1'b0, 1'b0, 10};
    vecs[4]  = '{1'b1, 8'd17,  8'hFB,  8'hFD,  8'h02,  1'b0, 1'b0, 10};
    vecs[5]  = '{1'b1, 8'h80,  8'hFF,  8'h80,  8'h00,  1'b0, 1'b1, 1};
    vecs[6]  = '{1'b0, 8'h80,  8'hFF,  8'h00,  8'h80,  1'b0, 1'b0, 10};
    vecs[7]  = '{1'b0, 8'd200, 8'd200, 8'd1,   8'd0,   1'b0, 1'b0, 10};
    vecs[8]  = '{1'b1, 8'hF9,  8'hFE,  8'h03,  8'hFF,  1'b0, 1'b0, 10};
    vecs[9]  = '{1'b1, 8'd5,   8'd0,   8'hFF,  8'h05,  1'b1, 1'b0, 1};
    vecs[10] = '{1'b0, 8'd7,   8'd9,   8'h00,  8'h07,  1'b0, 1'b0, 10};
    vecs[11] = '{1'b1, 8'h81,  8'h7F,  8'hFF,  8'h00,  1'b0, 1'b0, 10};

    repeat (2) @(negedge clk);
    chk("reset_out8", {q8, r8, busy8, done8, dz8, ov8}, 32'h0);
    chk("reset_out16", {q16, r16}, 32'h0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      run_op(1'b0, vecs[i].sop, {8'h00, vecs[i].a}, {8'h00, vecs[i].b}, q, r, dz, ov, lat, busy_n, narrow);
      chk($sformatf("v%0d_Q", i), q, {8'h00, vecs[i].q});
      chk($sformatf("v%0d_R", i), r, {8'h00, vecs[i].r});
      chk($sformatf("v%0d_flags", i), {dz, ov}, {vecs[i].dz, vecs[i].ov});
      chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_busy_cycles", i), busy_n, (vecs[i].lat == 10) ? 9 : 0);
      chk($sformatf("v%0d_done_width", i), narrow, 1'b1);
    end

    // Start pulses while busy and operand changes after the start edge are ignored.
    @(negedge clk);
    sop8 = 1'b0; a8 = 8'd255; b8 = 8'd10; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      if (done8) begin lat = k; break; end
      a8 = 8'd3; b8 = 8'd1; sop8 = 1'b1;
      start8 = (k >= 1 && k <= 4);
      @(negedge clk);
    end
    chk("ignore_lat", lat, 10);
    chk("ignore_Q", q8, 8'd25);
    chk("ignore_R", r8, 8'd5);
    @(negedge clk);
    chk("ignore_no_requeue", {busy8, done8}, 2'b00);

    // Start held high: a new op begins on the IDLE cycle after each DONE.
    sop8 = 1'b0; a8 = 8'd17; b8 = 8'd5; start8 = 1'b1;
    d1 = 0; d2 = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done8 && d1 == 0) d1 = k;
      else if (done8 && d1 != 0) begin d2 = k; start8 = 1'b0; break; end
    end
    start8 = 1'b0;
    chk("held_start_gap", d2 - d1, 11);
    chk("held_start_Q", q8, 8'd3);
    chk("held_start_R", r8, 8'd2);

    // Reset in the middle of CALC aborts with all outputs cleared and no done.
    @(negedge clk);
    sop8 = 1'b0; a8 = 8'd255; b8 = 8'd10; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midreset_out", {q8, r8, busy8, done8, dz8, ov8}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    d1 = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8 || busy8) d1++;
    end
    chk("midreset_no_done", d1, 0);
    run_op(1'b0, 1'b0, 16'd20, 16'd4, q, r, dz, ov, lat, busy_n, narrow);
    chk("after_reset_QR", {q, r}, {16'd5, 16'd0});
    chk("after_reset_lat", lat, 10);

    // WIDTH=16 instance.
    run_op(1'b1, 1'b0, 16'd65535, 16'd255, q, r, dz, ov, lat, busy_n, narrow);
    chk("w16_u_QR", {q, r}, {16'd257, 16'd0});
    chk("w16_u_lat", lat, 18);
    chk("w16_u_busy", busy_n, 17);
    chk("w16_u_width", narrow, 1'b1);
    run_op(1'b1, 1'b1, 16'h8000, 16'd3, q, r, dz, ov, lat, busy_n, narrow);
    chk("w16_s_QR", {q, r}, {16'hD556, 16'hFFFE});
    chk("w16_s_flags", {dz, ov}, 2'b00);
    run_op(1'b1, 1'b1, 16'h8000, 16'hFFFF, q, r, dz, ov, lat, busy_n, narrow);
    chk("w16_ovf_QR", {q, r}, {16'h8000, 16'h0000});
    chk("w16_ovf_flags_lat", {dz, ov, lat[7:0]}, {2'b01, 8'd1});

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
